wb_regfile_hilo: RTL and testbench

- Architectural state sink at the far end of the MEM/WB pipeline register.
- Consumes the writeback bundle (GPR write, HI/LO write) and commits it to a 32x32 general-purpose register file plus the HI/LO pair.
- Serves two combinational GPR read ports and a HI/LO read port to decode/execute, with same-cycle write-through bypass so the ID stage never sees stale data from the instruction in WB.
- Keeps a wrapping commit counter for debug/perf.

---
 rtl/wb_regfile_hilo.sv | 100 ++++++++++
 tb/tb_wb_regfile_hilo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile_hilo.sv
// Writeback-stage architectural state: 32x32 GPR file, HI/LO pair and a commit counter.
// Read ports are combinational with same-cycle bypass of the bundle currently in WB.
module wb_regfile_hilo #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_we,
  input  logic [4:0]       wb_waddr,
  input  logic [31:0]      wb_wdata,
  input  logic             wb_we_hilo,
  input  logic [31:0]      wb_hi,
  input  logic [31:0]      wb_lo,
  input  logic             re1,
  input  logic [4:0]       raddr1,
  output logic [31:0]      rdata1,
  input  logic             re2,
  input  logic [4:0]       raddr2,
  output logic [31:0]      rdata2,
  output logic [31:0]      hi_o,
  output logic [31:0]      lo_o,
  output logic [CNT_W-1:0] commit_cnt
);

  logic [31:0]      gpr_reg [32];
  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             gpr_commit;

  logic [1:0]       re_vec;
  logic [4:0]       raddr_vec [2];
  logic [31:0]      rdata_vec [2];

  assign gpr_commit = wb_we && (wb_waddr != 5'd0);

  // Entry 0 is reset and never written, so it reads back as zero without a special case.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        gpr_reg[i] <= '0;
      end
    end else if (gpr_commit) begin
      gpr_reg[wb_waddr] <= wb_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (wb_we_hilo) begin
      hi_reg <= wb_hi;
      lo_reg <= wb_lo;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (gpr_commit) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign re_vec       = {re2, re1};
  assign raddr_vec[0] = raddr1;
  assign raddr_vec[1] = raddr2;

  // Outputs are forced to zero while reset is held so the bypass path cannot leak.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        rdata_vec[gi] = '0;
        if (!rst || !re_vec[gi] || raddr_vec[gi] == 5'd0) begin
          rdata_vec[gi] = '0;
        end else if (wb_we && wb_waddr == raddr_vec[gi]) begin
          rdata_vec[gi] = wb_wdata;
        end else begin
          rdata_vec[gi] = gpr_reg[raddr_vec[gi]];
        end
      end
    end
  endgenerate

  assign rdata1 = rdata_vec[0];
  assign rdata2 = rdata_vec[1];

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (rst) begin
      hi_o = wb_we_hilo ? wb_hi : hi_reg;
      lo_o = wb_we_hilo ? wb_lo : lo_reg;
    end
  end

  assign commit_cnt = cnt_reg;

endmodule

// File: tb/tb_wb_regfile_hilo.sv
// Directed bench for wb_regfile_hilo: vector table for steady-state behaviour,
// hand-written sequences for reset, counter wrap and asynchronous reset.
module tb_wb_regfile_hilo;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             wb_we;
  logic [4:0]       wb_waddr;
  logic [31:0]      wb_wdata;
  logic             wb_we_hilo;
  logic [31:0]      wb_hi;
  logic [31:0]      wb_lo;
  logic             re1;
  logic [4:0]       raddr1;
  logic [31:0]      rdata1;
  logic             re2;
  logic [4:0]       raddr2;
  logic [31:0]      rdata2;
  logic [31:0]      hi_o;
  logic [31:0]      lo_o;
  logic [CNT_W-1:0] commit_cnt;

  int checks = 0;
  int errors = 0;

  wb_regfile_hilo #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_we      (wb_we),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .wb_we_hilo (wb_we_hilo),
    .wb_hi      (wb_hi),
    .wb_lo      (wb_lo),
    .re1        (re1),
    .raddr1     (raddr1),
    .rdata1     (rdata1),
    .re2        (re2),
    .raddr2     (raddr2),
    .rdata2     (rdata2),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .commit_cnt (commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we_hilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        r1;
    logic [4:0]  a1;
    logic        r2;
    logic [4:0]  a2;
    logic [31:0] exp_d1;
    logic [31:0] exp_d2;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    wb_we_hilo = 1'b0; wb_hi = '0; wb_lo = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Cumulative state and pre-edge counter value noted per row.
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,    32'h0,    1'b1, 5'd5, 1'b1, 5'd31, 32'h0,        32'h0,        32'h0,    32'h0,    4'd0};
    vecs[1]  = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 32'h0,    32'h0,    1'b1, 5'd3, 1'b0, 5'd3,  32'hDEADBEEF, 32'h0,        32'h0,    32'h0,    4'd0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,    32'h0,    1'b1, 5'd3, 1'b1, 5'd3,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,    32'h0,    4'd1};
    vecs[3]  = '{1'b1, 5'd7,  32'h11,       1'b0, 32'h0,    32'h0,    1'b1, 5'd7, 1'b0, 5'd0,  32'h11,       32'h0,        32'h0,    32'h0,    4'd1};
    vecs[4]  = '{1'b1, 5'd7,  32'h22,       1'b0, 32'h0,    32'h0,    1'b1, 5'd7, 1'b1, 5'd7,  32'h22,       32'h22,       32'h0,    32'h0,    4'd2};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,    32'h0,    1'b1, 5'd7, 1'b0, 5'd7,  32'h22,       32'h0,        32'h0,    32'h0,    4'd3};
    vecs[6]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 32'h0,    32'h0,    1'b1, 5'd0, 1'b1, 5'd3,  32'h0,        32'hDEADBEEF, 32'h0,    32'h0,    4'd3};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,    32'h0,    1'b1, 5'd0, 1'b1, 5'd0,  32'h0,        32'h0,        32'h0,    32'h0,    4'd3};
    vecs[8]  = '{1'b1, 5'd4,  32'h44,       1'b1, 32'h1,    32'h2,    1'b1, 5'd4, 1'b1, 5'd7,  32'h44,       32'h22,       32'h1,    32'h2,    4'd3};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,    32'h0,    1'b1, 5'd4, 1'b1, 5'd3,  32'h44,       32'hDEADBEEF, 32'h1,    32'h2,    4'd4};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,    32'h0,    1'b0, 5'd4, 1'b1, 5'd5,  32'h0,        32'h0,        32'h1,    32'h2,    4'd4};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 32'hAAAA, 32'hBBBB, 1'b1, 5'd4, 1'b1, 5'd7,  32'h44,       32'h22,       32'hAAAA, 32'hBBBB, 4'd4};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,    32'h0,    1'b1, 5'd1, 1'b1, 5'd4,  32'h0,        32'h44,       32'hAAAA, 32'hBBBB, 4'd4};

    // Reset held for two edges with writes and bypass requests that must be ignored.
    rst = 1'b0;
    idle_inputs();
    wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h12345678;
    wb_we_hilo = 1'b1; wb_hi = 32'h9; wb_lo = 32'h8;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
    #3;
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_rdata2", rdata2, 32'h0);
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    next_cycle();
    next_cycle();
    idle_inputs();
    rst = 1'b1;
    #1;
    re1 = 1'b1; raddr1 = 5'd5;
    #1;
    chk("post_rst_r5", rdata1, 32'h0);
    chk("post_rst_cnt", 32'(commit_cnt), 32'h0);
    $display("reset sequence: r5=%08h cnt=%0d", rdata1, commit_cnt);
    next_cycle();

    for (int i = 0; i < 13; i++) begin
      wb_we = vecs[i].we; wb_waddr = vecs[i].waddr; wb_wdata = vecs[i].wdata;
      wb_we_hilo = vecs[i].we_hilo; wb_hi = vecs[i].hi; wb_lo = vecs[i].lo;
      re1 = vecs[i].r1; raddr1 = vecs[i].a1; re2 = vecs[i].r2; raddr2 = vecs[i].a2;
      #3;
      chk($sformatf("v%0d_rdata1", i), rdata1, vecs[i].exp_d1);
      chk($sformatf("v%0d_rdata2", i), rdata2, vecs[i].exp_d2);
      chk($sformatf("v%0d_hi", i), hi_o, vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i), lo_o, vecs[i].exp_lo);
      chk($sformatf("v%0d_cnt", i), 32'(commit_cnt), 32'(vecs[i].exp_cnt));
      $display("vec %0d: rd1=%08h rd2=%08h hi=%08h lo=%08h cnt=%0d", i, rdata1, rdata2, hi_o, lo_o, commit_cnt);
      next_cycle();
    end

    // Four commits so far; twelve more wrap a 4-bit counter back to zero.
    idle_inputs();
    for (int a = 8; a < 20; a++) begin
      wb_we = 1'b1; wb_waddr = 5'(a); wb_wdata = 32'(a) * 32'h101;
      next_cycle();
    end
    idle_inputs();
    re1 = 1'b1; raddr1 = 5'd19; re2 = 1'b1; raddr2 = 5'd8;
    #1;
    chk("wrap_cnt", 32'(commit_cnt), 32'h0);
    chk("wrap_r19", rdata1, 32'h1313);
    chk("wrap_r8", rdata2, 32'h808);
    $display("wrap: cnt=%0d r19=%08h r8=%08h", commit_cnt, rdata1, rdata2);

    // One more commit so the asynchronous reset has a non-zero counter to clear.
    next_cycle();
    wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h55;
    next_cycle();
    idle_inputs();
    re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd19;
    #1;
    chk("pre_arst_cnt", 32'(commit_cnt), 32'h1);
    chk("pre_arst_r3", rdata1, 32'h55);
    #1;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_r3", rdata1, 32'h0);
    chk("arst_r19", rdata2, 32'h0);
    chk("arst_hi", hi_o, 32'h0);
    chk("arst_lo", lo_o, 32'h0);
    chk("arst_cnt", 32'(commit_cnt), 32'h0);
    $display("async reset: r3=%08h r19=%08h hi=%08h lo=%08h cnt=%0d", rdata1, rdata2, hi_o, lo_o, commit_cnt);

    // A write presented while reset is held across an edge is lost.
    next_cycle();
    rst = 1'b0;
    wb_we = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'h5;
    wb_we_hilo = 1'b1; wb_hi = 32'h7; wb_lo = 32'h6;
    next_cycle();
    rst = 1'b1;
    idle_inputs();
    re1 = 1'b1; raddr1 = 5'd9;
    #1;
    chk("lost_r9", rdata1, 32'h0);
    chk("lost_hi", hi_o, 32'h0);
    chk("lost_cnt", 32'(commit_cnt), 32'h0);
    $display("lost write: r9=%08h hi=%08h cnt=%0d", rdata1, hi_o, commit_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
